// File: rtl/ad9866_pkg.sv
// ad9866_pkg: shared constants, frame layout and helpers for the AD9866
// configuration-port target.
//   - bus widths (address, data, frame)
//   - R/W bit position inside a frame
//   - register address constants used by the RX/TX paths
//   - ad9866_frame_t: decoded view of a 16-bit instruction/data frame
//   - ad9866_addr_ok(): range check against the implemented register count
package ad9866_pkg;

  localparam int AD9866_ADDR_W  = 5;
  localparam int AD9866_DATA_W  = 8;
  localparam int AD9866_FRAME_W = 16;
  localparam int AD9866_RW_BIT  = 15;

  localparam logic [AD9866_ADDR_W-1:0] AD9866_REG_SPI_CFG = 5'h00;
  localparam logic [AD9866_ADDR_W-1:0] AD9866_REG_RX_GAIN = 5'h09;
  localparam logic [AD9866_ADDR_W-1:0] AD9866_REG_TX_GAIN = 5'h0A;

  typedef struct packed {
    logic                     rw;
    logic [1:0]               mode;
    logic [AD9866_ADDR_W-1:0] addr;
    logic [AD9866_DATA_W-1:0] data;
  } ad9866_frame_t;

  // True when addr falls inside the implemented register range.
  function automatic logic ad9866_addr_ok(input logic [AD9866_ADDR_W-1:0] addr,
                                          input int num_regs);
    return (int'(addr) < num_regs);
  endfunction

endpackage

// File: rtl/ad9866_regfile.sv
// ad9866_regfile: shadow register storage for the AD9866 target.
//   clk, reset            : clock, asynchronous active-high reset (all regs 0x00)
//   we, waddr, wdata      : single write port (caller guarantees waddr is in range)
//   spi_raddr / spi_rdata : combinational read port used by the SPI read path
//   loc_raddr / loc_rdata : combinational read port for local logic
// Reads of unimplemented addresses return 0x00.
module ad9866_regfile
  import ad9866_pkg::*;
#(
  parameter int NUM_REGS = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AD9866_ADDR_W-1:0] waddr,
  input  logic [AD9866_DATA_W-1:0] wdata,
  input  logic [AD9866_ADDR_W-1:0] spi_raddr,
  output logic [AD9866_DATA_W-1:0] spi_rdata,
  input  logic [AD9866_ADDR_W-1:0] loc_raddr,
  output logic [AD9866_DATA_W-1:0] loc_rdata
);

  logic [AD9866_DATA_W-1:0] r_mem [NUM_REGS];

  // Register storage: cleared on reset, one write per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read ports: out-of-range addresses read as zero.
  always_comb begin
    spi_rdata = 8'h00;
    loc_rdata = 8'h00;
    if (ad9866_addr_ok(spi_raddr, NUM_REGS)) begin
      spi_rdata = r_mem[spi_raddr];
    end else begin
      spi_rdata = 8'h00;
    end
    if (ad9866_addr_ok(loc_raddr, NUM_REGS)) begin
      loc_rdata = r_mem[loc_raddr];
    end else begin
      loc_rdata = 8'h00;
    end
  end

endmodule

// File: rtl/ad9866_spi_target.sv
// ad9866_spi_target: SPI target modelling the AD9866 configuration port.
// Oversamples sclk/sen_n/sdio on clk, assembles 16-bit R/W frames (MSB first)
// and keeps a shadow register file.
//   clk, reset          : system clock, asynchronous active-high reset
//   sclk, sen_n, sdio   : SPI inputs from the initiator
//   sdo, sdo_oe         : serial read data and its drive enable
//   rd_addr, rd_data    : local combinational read port
//   wr_strobe, wr_addr,
//   wr_data             : one-cycle notification of each committed write
//   frame_err           : one-cycle pulse per discarded frame
module ad9866_spi_target
  import ad9866_pkg::*;
#(
  parameter int NUM_REGS    = 20,
  parameter int SYNC_STAGES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     sen_n,
  input  logic                     sdio,
  output logic                     sdo,
  output logic                     sdo_oe,
  input  logic [AD9866_ADDR_W-1:0] rd_addr,
  output logic [AD9866_DATA_W-1:0] rd_data,
  output logic                     wr_strobe,
  output logic [AD9866_ADDR_W-1:0] wr_addr,
  output logic [AD9866_DATA_W-1:0] wr_data,
  output logic                     frame_err
);

  logic w_sclk;
  logic w_sen_n;
  logic w_sdio;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign w_sclk  = sclk;
      assign w_sen_n = sen_n;
      assign w_sdio  = sdio;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sclk_q;
      logic [SYNC_STAGES-1:0] r_sen_q;
      logic [SYNC_STAGES-1:0] r_sdio_q;

      // Input synchronizer chains; sen_n idles high.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sclk_q <= '0;
          r_sen_q  <= '1;
          r_sdio_q <= '0;
        end else begin
          r_sclk_q <= SYNC_STAGES'({r_sclk_q, sclk});
          r_sen_q  <= SYNC_STAGES'({r_sen_q, sen_n});
          r_sdio_q <= SYNC_STAGES'({r_sdio_q, sdio});
        end
      end

      assign w_sclk  = r_sclk_q[SYNC_STAGES-1];
      assign w_sen_n = r_sen_q[SYNC_STAGES-1];
      assign w_sdio  = r_sdio_q[SYNC_STAGES-1];
    end
  endgenerate

  logic                      r_sclk_prev;
  logic                      r_sen_prev;
  // r_armed is cleared by reset and set once sen_n is seen high, so a frame
  // interrupted by reset is ignored until the initiator starts a new one.
  logic                      r_armed;
  logic                      r_discard;
  logic [4:0]                r_bit_cnt;
  logic [AD9866_FRAME_W-2:0] r_shift;
  logic [AD9866_DATA_W-1:0]  r_sdo_sh;
  logic                      r_sdo_oe;
  logic                      r_wr_strobe;
  logic [AD9866_ADDR_W-1:0]  r_wr_addr;
  logic [AD9866_DATA_W-1:0]  r_wr_data;
  logic                      r_frame_err;

  logic [AD9866_FRAME_W-1:0] w_shift_next;
  ad9866_frame_t             w_frame;
  logic                      w_capture;
  logic                      w_mode_bad;
  logic                      w_overflow;
  logic                      w_abort;
  logic                      w_rd_load;
  logic                      w_wr_en;
  logic [AD9866_DATA_W-1:0]  w_spi_rdata;

  // w_shift_next holds the frame including the bit being captured this cycle,
  // so decisions at bit indices 2, 7 and 15 see the freshly shifted bit.
  assign w_shift_next = {r_shift, w_sdio};
  assign w_frame      = ad9866_frame_t'(w_shift_next);
  assign w_capture    = w_sclk & ~r_sclk_prev & ~w_sen_n & r_armed;

  // After 3 bits, w_shift_next[1:0] are frame bits 14:13.
  assign w_mode_bad = w_capture && !r_discard && (r_bit_cnt == 5'd2) &&
                      (w_shift_next[1:0] != 2'b00);
  assign w_overflow = w_capture && !r_discard && (r_bit_cnt == 5'd16);
  assign w_abort    = w_sen_n && !r_sen_prev && r_armed && !r_discard &&
                      (r_bit_cnt != 5'd16);

  // After 8 bits, the low byte of w_shift_next is frame bits 15:8.
  assign w_rd_load = w_capture && !r_discard && (r_bit_cnt == 5'd7) &&
                     w_shift_next[AD9866_RW_BIT-AD9866_DATA_W];
  assign w_wr_en   = w_capture && !r_discard && (r_bit_cnt == 5'd15) &&
                     !w_frame.rw && (w_frame.mode == 2'b00) &&
                     ad9866_addr_ok(w_frame.addr, NUM_REGS);

  ad9866_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (w_wr_en),
    .waddr     (w_frame.addr),
    .wdata     (w_frame.data),
    .spi_raddr (w_shift_next[AD9866_ADDR_W-1:0]),
    .spi_rdata (w_spi_rdata),
    .loc_raddr (rd_addr),
    .loc_rdata (rd_data)
  );

  // Frame sequencer: bit capture, read shifter, write notification, errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_prev <= 1'b0;
      r_sen_prev  <= 1'b1;
      r_armed     <= 1'b0;
      r_discard   <= 1'b0;
      r_bit_cnt   <= 5'd0;
      r_shift     <= '0;
      r_sdo_sh    <= 8'h00;
      r_sdo_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 5'd0;
      r_wr_data   <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_sen_prev  <= w_sen_n;
      r_frame_err <= w_mode_bad | w_overflow | w_abort;
      r_wr_strobe <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= w_frame.addr;
        r_wr_data <= w_frame.data;
      end

      if (w_sen_n) begin
        r_armed   <= 1'b1;
        r_discard <= 1'b0;
        r_bit_cnt <= 5'd0;
        r_shift   <= '0;
        r_sdo_sh  <= 8'h00;
        r_sdo_oe  <= 1'b0;
      end else if (w_capture) begin
        if (w_mode_bad || w_overflow) begin
          r_discard <= 1'b1;
        end
        // Bits beyond the 16th are dropped and the counter saturates.
        if (r_bit_cnt != 5'd16) begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
          r_shift   <= w_shift_next[AD9866_FRAME_W-2:0];
          if (w_rd_load) begin
            r_sdo_sh <= w_spi_rdata;
            r_sdo_oe <= 1'b1;
          end else begin
            r_sdo_sh <= {r_sdo_sh[AD9866_DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign sdo       = r_sdo_sh[AD9866_DATA_W-1];
  assign sdo_oe    = r_sdo_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ad9866_spi_target.sv
// Directed bench for ad9866_spi_target: drives SPI frames as an initiator
// (SCLK period of 2 clk), shifts in sdo on read frames, and compares against
// hand-computed expectations.
module tb_ad9866_spi_target;
  import ad9866_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       sen_n = 1'b1;
  logic       sdio = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic       sdo;
  logic       sdo_oe;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;

  ad9866_spi_target #(.NUM_REGS(20), .SYNC_STAGES(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sen_n     (sen_n),
    .sdio      (sdio),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int n_err = 0;
  int w0, e0;
  logic [7:0]  rx_byte;
  logic [15:0] oe_mask;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_wr++;
    if (frame_err === 1'b1) n_err++;
  end

  logic [7:0] init_val [20] = '{8'h80, 8'h1C, 8'h2A, 8'h00, 8'h06, 8'h44, 8'h03,
                                8'h21, 8'h0F, 8'h2F, 8'h10, 8'h00, 8'h41, 8'h55,
                                8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09};
  logic       init_en  [20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic open_frame();
    @(posedge clk); #1 sen_n = 1'b0;
    rx_byte = 8'h00;
    oe_mask = 16'h0000;
  endtask

  // One bit: sclk low for one clk with data set up, then high for one clk.
  // sdo/sdo_oe are sampled in the middle of the high phase.
  task automatic send_bit(input logic b, input int idx);
    @(posedge clk); #1 sdio = b; sclk = 1'b0;
    @(posedge clk); #1 sclk = 1'b1;
    @(negedge clk);
    if (idx >= 0 && idx <= 15) oe_mask[15-idx] = sdo_oe;
    if (idx >= 8 && idx <= 15) rx_byte = {rx_byte[6:0], sdo};
  endtask

  task automatic close_frame();
    @(posedge clk); #1 sclk = 1'b0;
    @(posedge clk); #1 sen_n = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits);
    open_frame();
    for (int i = 0; i < nbits; i++) send_bit((i < 16) ? f[15-i] : 1'b1, i);
    close_frame();
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [7:0] e, input string tag);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, e);
  endtask

  initial begin
    logic [15:0] f;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_sdo_oe", sdo_oe, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    rd_chk(AD9866_REG_RX_GAIN, 8'h00, "rst_reg09");

    // Write 0x7F to RX gain.
    w0 = n_wr; e0 = n_err;
    send_frame(16'h097F, 16);
    settle();
    rd_chk(AD9866_REG_RX_GAIN, 8'h7F, "wr_reg09");
    chk("wr_strobe_cnt", n_wr - w0, 1);
    chk("wr_err_cnt", n_err - e0, 0);
    chk("wr_addr", wr_addr, 5'h09);
    chk("wr_data", wr_data, 8'h7F);
    chk("wr_oe_mask", oe_mask, 16'h0000);

    // Read it back over sdo.
    w0 = n_wr; e0 = n_err;
    send_frame(16'h8900, 16);
    settle();
    chk("rd_sdo_byte", rx_byte, 8'h7F);
    chk("rd_oe_mask", oe_mask, 16'h00FF);
    chk("rd_oe_after", sdo_oe, 1'b0);
    chk("rd_strobe_cnt", n_wr - w0, 0);
    rd_chk(AD9866_REG_RX_GAIN, 8'h7F, "rd_reg09_kept");

    // Read of an unimplemented address returns zero.
    send_frame(16'h9500, 16);
    settle();
    chk("rd_oor_byte", rx_byte, 8'h00);
    chk("rd_oor_oe_mask", oe_mask, 16'h00FF);

    // Aborted frame after 10 bits.
    w0 = n_wr; e0 = n_err;
    send_frame(16'h0A55, 10);
    settle();
    chk("abort_err_cnt", n_err - e0, 1);
    chk("abort_strobe_cnt", n_wr - w0, 0);
    rd_chk(AD9866_REG_TX_GAIN, 8'h00, "abort_reg0a");

    // Write to address 0x14 is silently ignored.
    w0 = n_wr; e0 = n_err;
    send_frame(16'h1455, 16);
    settle();
    chk("oor_strobe_cnt", n_wr - w0, 0);
    chk("oor_err_cnt", n_err - e0, 0);

    // Bits 14:13 = 01 is discarded.
    w0 = n_wr; e0 = n_err;
    send_frame(16'h2B11, 16);
    settle();
    chk("mode_err_cnt", n_err - e0, 1);
    chk("mode_strobe_cnt", n_wr - w0, 0);
    rd_chk(5'h0B, 8'h00, "mode_reg0b");

    // 17 capture edges: one error pulse.
    w0 = n_wr; e0 = n_err;
    send_frame(16'h1F00, 17);
    settle();
    chk("ovf_err_cnt", n_err - e0, 1);
    chk("ovf_strobe_cnt", n_wr - w0, 0);

    // Initiator init table, frames back to back.
    w0 = n_wr; e0 = n_err;
    for (int i = 0; i < 20; i++) begin
      if (init_en[i]) begin
        f = {3'b000, i[4:0], init_val[i]};
        send_frame(f, 16);
      end
    end
    settle();
    chk("init_strobe_cnt", n_wr - w0, 13);
    chk("init_err_cnt", n_err - e0, 0);
    rd_chk(AD9866_REG_SPI_CFG, 8'h80, "init_reg00");
    rd_chk(5'h04, 8'h06, "init_reg04");
    rd_chk(5'h07, 8'h21, "init_reg07");
    rd_chk(5'h0C, 8'h41, "init_reg0c");
    rd_chk(5'h13, 8'h09, "init_reg13");
    rd_chk(AD9866_REG_RX_GAIN, 8'h7F, "init_reg09_kept");

    // Reset in the middle of a frame; remaining bits must be ignored.
    w0 = n_wr; e0 = n_err;
    f = 16'h0955;
    open_frame();
    for (int i = 0; i < 12; i++) send_bit(f[15-i], i);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 12; i < 16; i++) send_bit(f[15-i], i);
    close_frame();
    settle();
    chk("rstmid_strobe_cnt", n_wr - w0, 0);
    chk("rstmid_err_cnt", n_err - e0, 0);
    rd_chk(AD9866_REG_SPI_CFG, 8'h00, "rstmid_reg00");
    rd_chk(AD9866_REG_RX_GAIN, 8'h00, "rstmid_reg09");
    rd_chk(5'h0C, 8'h00, "rstmid_reg0c");

    // Normal operation afterwards.
    w0 = n_wr;
    send_frame(16'h0933, 16);
    settle();
    rd_chk(AD9866_REG_RX_GAIN, 8'h33, "post_reg09");
    chk("post_strobe_cnt", n_wr - w0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ad9866_spi_target.md
# ad9866_spi_target

Synthesizable SPI target that models the AD9866 configuration port: it receives the 16-bit instruction/data frames produced by the AD9866 SPI initiator, maintains a shadow register file, and returns register contents on `sdo` for read frames. It sits in the same `clk` domain as the initiator and is used in loopback benches and as an on-chip register shadow for the gain and filter state that the RX/TX paths need to know.

## Interface
- `NUM_REGS`, default 20: number of implemented registers at addresses 0x00..NUM_REGS-1 (max 32).
- `SYNC_STAGES`, default 0: input synchronizer depth on `sclk`/`sen_n`/`sdio`. Use 0 for same-domain use; a value of 2 or more requires an SCLK period of at least 2·(SYNC_STAGES+2) clk.
- `clk` in 1: system clock; all SPI inputs are sampled on its rising edge.
- `reset` in 1: asynchronous, active-high reset; clock `clk`.
- `sclk` in 1: SPI clock from the initiator; its high phase is at least 1 clk.
- `sen_n` in 1: active-low frame enable.
- `sdio` in 1: serial data in, MSB first.
- `sdo` out 1: serial read data, MSB first.
- `sdo_oe` out 1: high while read data is being driven.
- `rd_addr` in 5: local read port address.
- `rd_data` out 8: register content at `rd_addr`, combinational.
- `wr_strobe` out 1: one-cycle pulse for each committed SPI write.
- `wr_addr` out 5: address of the last committed write.
- `wr_data` out 8: data of the last committed write.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Frame layout: bit15 is R/W (1 = read); bits 14:13 must be 00; bits 12:8 are the address; bits 7:0 are the data.
- Capture edge: the cycle where the sampled `sclk` is 1, the previous sample is 0, and `sen_n` is 0. On that edge:
  - shift `sdio` into a 16-bit shift register;
  - increment a 5-bit bit counter, which saturates at 16.
- While `sen_n` is 1: the bit counter is held at 0 and `sdo_oe` is 0.
- Read frames:
  - On the capture edge of bit index 7 (8th bit), if R/W = 1, load an 8-bit output shifter with reg[addr].
  - If addr ≥ NUM_REGS, load 0x00 instead.
  - `sdo` is the shifter MSB. It shifts left on each later capture edge.
  - `sdo_oe` is 1 from that load until `sen_n` rises.
- Write frames:
  - On the capture edge of bit index 15, if R/W = 0, bits 14:13 = 00, and addr < NUM_REGS: write reg[addr] and set `wr_addr`/`wr_data`.
  - `wr_strobe` is high for the following cycle only.
- Discard conditions. Each produces exactly one `frame_err` pulse, in the cycle after the event, and no register change:
  - `sen_n` rises with bit count ≠ 16;
  - bits 14:13 ≠ 00;
  - more than 16 capture edges in one frame (the error is flagged at the 17th edge, and further bits are ignored).
- A write to addr ≥ NUM_REGS is silently ignored: no `wr_strobe` and no `frame_err`.
- Reads never modify state.

## Timing
- Reset values:
  - all registers 0x00;
  - `sdo` 0, `sdo_oe` 0, `wr_strobe` 0, `frame_err` 0;
  - `wr_addr` 0, `wr_data` 0;
  - bit counter 0, shifters 0.
- `sclk` history resets to 0.
- Write latency:
  - the register is updated at the 16th capture edge;
  - `rd_data` reflects the new value from the next cycle;
  - `wr_strobe` is high in that same next cycle.
- Read data timing: `sdo` bit n is stable throughout the high phase of SCLK for frame bit 8+n. With SCLK toggling every clk, the initiator samples at the end of that high cycle.
- A `sen_n` rise and a capture edge never coincide. If they do, `sen_n` wins and the bit is dropped.
- Reset mid-frame: all state clears immediately and the partial frame is lost. Until the next `sen_n` fall, the frame in progress is ignored.
- Back-to-back frames: a single clk of `sen_n` high between frames is sufficient.

## Structure
- Package `ad9866_pkg`:
  - `AD9866_ADDR_W=5`, `AD9866_DATA_W=8`, `AD9866_FRAME_W=16`;
  - the R/W bit index;
  - the register address constants (0x09 RX gain, 0x0A TX gain, 0x00 SPI config).
- Sub-module `ad9866_regfile`: NUM_REGS×8 storage, async reset, one write port, and two combinational read ports (SPI and local).

## Test plan
- Write frame 16'h097F, then `rd_addr`=0x09 → `rd_data`=0x7F. Also one `wr_strobe` with `wr_addr`=0x09, `wr_data`=0x7F, and no `frame_err`.
- After the above, read frame 16'h8900 with the initiator shifting in `sdo` → last 8 bits received = 0x7F, `sdo_oe` high for bits 8..15, and reg 0x09 unchanged.
- Abort: 10 bits of 16'h0A55, then `sen_n` high → `frame_err` pulse, reg 0x0A stays 0x00, no `wr_strobe`.
- Out-of-range and bad-mode frames:
  - 16'h1455 → no `wr_strobe`, no `frame_err`;
  - 16'h2B11 (bits 14:13 = 01) → `frame_err` and reg 0x0B unchanged.
- Full 20-word init sequence from the initiator with default init values:
  - reg 0x00=0x80, 0x04=0x06, 0x07=0x21, 0x0C=0x41;
  - `wr_strobe` count equals the number of enabled entries (13).
- Reset asserted at bit 12 of 16'h0955 → all registers 0x00 and no `wr_strobe`. Next frame 16'h0933 → reg 0x09=0x33.
